axi_sim_ctrl: RTL and testbench

- AXI4-Lite slave on the unified-memory interconnect, directly upstream of the top-level testbench.
- The CPU writes TOHOST to end a test. The block then raises sim_done/exit_code, and the testbench ends simulation early instead of waiting for timeout.
- Also provides a buffered console byte stream for the testbench to drain, plus a free-running 64-bit cycle counter readable by software.

---
 rtl/axi_sim_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_sim_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sim_ctrl.sv
// AXI4-Lite simulation control slave: TOHOST end-of-test flag, console byte
// FIFO for the testbench to drain, and a free-running 64-bit cycle counter.
module axi_sim_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              sim_done,
    output logic [30:0]       exit_code,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic [1:0]  aw_sel_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;

    logic [63:0] cycle_cnt;
    logic [31:0] cycle_hi_shadow;
    logic [31:0] rdata_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          overflow;

    // Only ADDR[3:2] select a register; the rest is decoded upstream.
    logic unused_addr;
    assign unused_addr = &{1'b0, AWADDR[ADDR_W-1:4], AWADDR[1:0],
                           ARADDR[ADDR_W-1:4], ARADDR[1:0]};

    // Handshakes; readies are held low while reset is asserted.
    logic aw_hs, w_hs, ar_hs, commit;
    assign AWREADY = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_DATA);
    assign WREADY  = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
    assign ARREADY = !ARESET && (r_state == R_IDLE);
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign BVALID  = (w_state == W_RESP);
    assign BRESP   = bresp_q;
    assign RVALID  = (r_state == R_RESP);
    assign RDATA   = rdata_q;
    assign RRESP   = RESP_OKAY;

    // Effective commit operands: whichever half arrived earlier comes from its latch.
    logic [1:0]  c_sel;
    logic [31:0] c_data;
    logic [3:0]  c_strb;
    assign c_sel  = (w_state == W_HAVE_ADDR) ? aw_sel_q : AWADDR[3:2];
    assign c_data = (w_state == W_HAVE_DATA) ? wdata_q  : WDATA;
    assign c_strb = (w_state == W_HAVE_DATA) ? wstrb_q  : WSTRB;

    // Write FSM state register and AW/W latches.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state  <= W_IDLE;
            aw_sel_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) aw_sel_q <= AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
        end
    end

    // Write FSM next state; commit fires on the edge where both halves are held.
    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: if (w_hs) begin
                commit = 1'b1;
                w_next = W_RESP;
            end
            W_HAVE_DATA: if (aw_hs) begin
                commit = 1'b1;
                w_next = W_RESP;
            end
            W_RESP: if (BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Register-map decode of the committing write.
    logic push, tohost_ok, bad_wr;
    always_comb begin
        push      = 1'b0;
        tohost_ok = 1'b0;
        bad_wr    = 1'b0;
        if (commit) begin
            case (c_sel)
                2'd0:    if (c_strb == 4'hF) tohost_ok = 1'b1; else bad_wr = 1'b1;
                2'd1:    push   = c_strb[0];
                default: bad_wr = 1'b1;
            endcase
        end
    end

    // TOHOST state and the write response code.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sim_done  <= 1'b0;
            exit_code <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (commit) bresp_q <= bad_wr ? RESP_SLVERR : RESP_OKAY;
            if (tohost_ok && c_data[0] && !sim_done) begin
                sim_done  <= 1'b1;
                exit_code <= c_data[31:1];
            end
        end
    end

    // Cycle counter runs until the test ends, then freezes for post-mortem reads.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) cycle_cnt <= '0;
        else if (!sim_done) cycle_cnt <= cycle_cnt + 64'd1;
    end

    // Console FIFO pointers and level; a push to a full FIFO only lands if a pop frees a slot.
    logic pop, push_ok;
    assign char_valid = (level != '0);
    assign char_data  = char_valid ? mem[rd_ptr] : 8'h00;
    assign pop        = char_valid && char_ready;
    assign push_ok    = push && ((level != LW'(FIFO_DEPTH)) || pop);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      level <= level + LW'(1);
            else if (pop && !push_ok) level <= level - LW'(1);
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // FIFO storage needs no reset; char_data is masked while empty.
    always_ff @(posedge ACLK) begin
        if (push_ok) mem[wr_ptr] <= c_data[7:0];
    end

    // Read data mux over pre-edge register values.
    logic [31:0] level_ext, rd_mux;
    assign level_ext = 32'(level);
    always_comb begin
        case (ARADDR[3:2])
            2'd0:    rd_mux = {exit_code, sim_done};
            2'd1:    rd_mux = {23'b0, overflow, level_ext[7:0]};
            2'd2:    rd_mux = cycle_cnt[31:0];
            default: rd_mux = cycle_hi_shadow;
        endcase
    end

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM state, registered RDATA, and the CYCLE_HI shadow captured on CYCLE_LO reads.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state         <= R_IDLE;
            rdata_q         <= '0;
            cycle_hi_shadow <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rdata_q <= rd_mux;
                if (ARADDR[3:2] == 2'd2) cycle_hi_shadow <= cycle_cnt[63:32];
            end
        end
    end

endmodule

// File: tb/tb_axi_sim_ctrl.sv
// Directed bench for axi_sim_ctrl: TOHOST, console FIFO, cycle counter, error responses, reset.
module tb_axi_sim_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic        AWVALID, WVALID, BREADY, ARVALID, RREADY, char_ready;
    logic [3:0]  WSTRB;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, sim_done, char_valid;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;
    logic [30:0] exit_code;
    logic [7:0]  char_data;

    int n_cmp = 0;
    int n_err = 0;

    axi_sim_ctrl #(.ADDR_W(32), .FIFO_DEPTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .sim_done(sim_done), .exit_code(exit_code),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARVALID = 0; RREADY = 0; char_ready = 0;
        ARESET = 1;
        cyc(); cyc();
        ARESET = 0;
        cyc();
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n = 0;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
        cyc();
        AWVALID = 0; WVALID = 0;
        while (!BVALID && n < 20) begin cyc(); n++; end
        chk("bvalid_wait", BVALID, 1);
        resp = BRESP;
        BREADY = 1;
        cyc();
        BREADY = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        ARADDR = a; ARVALID = 1;
        cyc();
        ARVALID = 0;
        while (!RVALID && n < 20) begin cyc(); n++; end
        chk("rvalid_wait", RVALID, 1);
        d = RDATA;
        RREADY = 1;
        cyc();
        RREADY = 0;
    endtask

    logic [1:0]  r;
    logic [31:0] d, lo1, lo2;

    initial begin
        // Reset state, with reset still asserted for ready checks.
        AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARVALID = 0; RREADY = 0; char_ready = 0;
        ARESET = 1;
        cyc();
        chk("rst_awready", AWREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_sim_done", sim_done, 0);
        chk("rst_exit_code", exit_code, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_rdata", RDATA, 0);
        ARESET = 0;
        cyc();
        chk("idle_awready", AWREADY, 1);
        chk("idle_wready", WREADY, 1);

        // AW first, W three cycles later.
        AWADDR = 32'h0; AWVALID = 1;
        cyc();
        AWVALID = 0;
        chk("ha_awready", AWREADY, 0);
        chk("ha_wready", WREADY, 1);
        cyc(); cyc();
        chk("ha_bvalid_early", BVALID, 0);
        WDATA = 32'h1; WSTRB = 4'hF; WVALID = 1;
        cyc();
        WVALID = 0;
        chk("t1_bvalid", BVALID, 1);
        chk("t1_bresp", BRESP, 2'b00);
        chk("t1_sim_done", sim_done, 1);
        chk("t1_exit_code", exit_code, 0);
        BREADY = 1;
        cyc();
        BREADY = 0;
        chk("t1_bvalid_clr", BVALID, 0);
        axi_write(32'h0, 32'h0000000B, 4'hF, r);
        chk("t1_resp2", r, 2'b00);
        chk("t1_exit_sticky", exit_code, 0);
        chk("t1_done_sticky", sim_done, 1);

        // W before AW.
        do_reset();
        WDATA = 32'h0000000B; WSTRB = 4'hF; WVALID = 1;
        cyc();
        WVALID = 0;
        chk("hd_awready", AWREADY, 1);
        chk("hd_wready", WREADY, 0);
        chk("hd_bvalid", BVALID, 0);
        AWADDR = 32'h0; AWVALID = 1;
        cyc();
        AWVALID = 0;
        chk("t2_bvalid", BVALID, 1);
        chk("t2_sim_done", sim_done, 1);
        chk("t2_exit_code", exit_code, 31'd5);
        BREADY = 1;
        cyc();
        BREADY = 0;
        axi_read(32'h0, d);
        chk("t2_tohost_rd", d, 32'h0000000B);

        // Console: "Hi".
        do_reset();
        axi_write(32'h4, 32'h48, 4'h1, r);
        chk("hi_resp", r, 2'b00);
        axi_write(32'h4, 32'h69, 4'h1, r);
        axi_write(32'h4, 32'h77, 4'hE, r);
        chk("nopush_resp", r, 2'b00);
        axi_read(32'h4, d);
        chk("hi_level", d, 32'h2);
        chk("hi_valid", char_valid, 1);
        char_ready = 1;
        chk("hi_c0", char_data, 8'h48);
        cyc();
        chk("hi_c1", char_data, 8'h69);
        chk("hi_c1_valid", char_valid, 1);
        cyc();
        chk("hi_empty", char_valid, 0);
        char_ready = 0;

        // Overflow: 17 pushes into 16 entries.
        for (int i = 0; i < 17; i++) axi_write(32'h4, 32'h30 + i, 4'h1, r);
        chk("ovf_resp", r, 2'b00);
        axi_read(32'h4, d);
        chk("ovf_status", d, 32'h110);
        char_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain_valid", char_valid, 1);
            chk("ovf_drain_data", char_data, 8'h30 + 8'(i));
            cyc();
        end
        chk("ovf_drained", char_valid, 0);
        char_ready = 0;
        axi_read(32'h4, d);
        chk("ovf_sticky", d, 32'h100);

        // Cycle counter: back-to-back LO reads are two cycles apart, HI shadow is 0.
        axi_read(32'h8, lo1);
        axi_read(32'hC, d);
        chk("cyc_hi", d, 0);
        axi_read(32'h8, lo1);
        axi_read(32'h8, lo2);
        chk("cyc_delta2", lo2 - lo1, 2);
        // A write to CYCLE_LO in between takes two edges and must not disturb the count.
        axi_read(32'h8, lo1);
        axi_write(32'h8, 32'h0, 4'hF, r);
        chk("cyc_wr_slverr", r, 2'b10);
        axi_read(32'h8, lo2);
        chk("cyc_delta4", lo2 - lo1, 4);
        axi_write(32'hC, 32'hFFFF_FFFF, 4'hF, r);
        chk("cychi_wr_slverr", r, 2'b10);

        // Partial-strobe TOHOST is rejected.
        axi_write(32'h0, 32'h1, 4'h1, r);
        chk("tohost_strb_slverr", r, 2'b10);
        chk("tohost_strb_nodone", sim_done, 0);
        axi_write(32'h0, 32'h2, 4'hF, r);
        chk("tohost_bit0_clr", sim_done, 0);

        // Counter freezes after sim_done.
        axi_write(32'h0, 32'h7, 4'hF, r);
        chk("frz_done", sim_done, 1);
        chk("frz_code", exit_code, 31'd3);
        axi_read(32'h8, lo1);
        repeat (10) cyc();
        axi_read(32'h8, lo2);
        chk("frz_equal", lo2, lo1);

        // Reset while BVALID is high drops the response and clears state.
        axi_write(32'h4, 32'h5A, 4'h1, r);
        chk("pre_rst_char", char_valid, 1);
        AWADDR = 32'h4; WDATA = 32'h11; WSTRB = 4'h1; AWVALID = 1; WVALID = 1;
        cyc();
        AWVALID = 0; WVALID = 0;
        chk("pre_rst_bvalid", BVALID, 1);
        ARESET = 1;
        #1;
        chk("arst_bvalid", BVALID, 0);
        chk("arst_sim_done", sim_done, 0);
        chk("arst_exit_code", exit_code, 0);
        chk("arst_char_valid", char_valid, 0);
        cyc();
        ARESET = 0;
        cyc(); cyc();
        chk("post_rst_bvalid", BVALID, 0);
        axi_read(32'h4, d);
        chk("post_rst_console", d, 0);
        axi_read(32'h0, d);
        chk("post_rst_tohost", d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
